rule_scheduler: RTL and testbench
=================================

RULE_SCHEDULER -- requirements
Module: rule_scheduler

Interface
- REQ-001 SHALL have parameter NUM_RULES, default 4, meaning the number of guarded rules driven (power of two, 2..16).
- REQ-002 SHALL have parameter DEADLOCK_LIMIT, default 8, meaning consecutive no-guard cycles before deadlock is flagged (1..255).
- REQ-003 SHALL have parameter CNT_W, default 16, meaning the fire counter width.
- REQ-004 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
- REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
- REQ-006 SHALL have port io_guard  input  NUM_RULES  bit i high = rule i guard true in the downstream system this cycle.
- REQ-007 SHALL have port io_stall  input  1  freeze scheduling; no rule is enabled while high.
- REQ-008 SHALL have port io_en_a  output  NUM_RULES  one-hot or zero rule enable, wired directly to the downstream system io_en_a.
- REQ-009 SHALL have port io_valid  output  1  high when io_en_a is non-zero.
- REQ-010 SHALL have port io_rule_idx  output  log2(NUM_RULES)  index of the enabled rule; 0 when io_valid is low.
- REQ-011 SHALL have port io_deadlock  output  1  sticky flag: no guard true for DEADLOCK_LIMIT cycles.
- REQ-012 SHALL have port io_fire_count  output  CNT_W  number of rules enabled since reset.

Function
- REQ-013 SHALL implement states FLUSH, RUN, DEAD; FLUSH -> RUN unconditionally after one cycle; RUN -> DEAD when the idle counter reaches DEADLOCK_LIMIT; DEAD exits only on reset.
- REQ-014 SHALL drive all outputs from registers; io_en_a reflects the io_guard sampled one cycle earlier (latency 1).
- REQ-015 SHALL, in RUN with io_stall low, select the first set guard bit searching from the start index upward with wrap-around modulo NUM_RULES.
- REQ-016 SHALL, on a selection of index k, register io_en_a = one-hot(k), io_valid = 1, io_rule_idx = k, pointer <= (k+1) mod NUM_RULES, and io_fire_count += 1.
- REQ-017 SHALL saturate io_fire_count at all-ones.
- REQ-018 SHALL never assert more than one bit of io_en_a.
- REQ-019 SHALL, in RUN with io_stall low and io_guard all zero, register io_en_a = 0 and increment the idle counter; any set guard clears the idle counter to 0.
- REQ-020 SHALL, when io_stall is high, register io_en_a = 0 and hold the pointer, the idle counter and io_fire_count; stall does not advance deadlock detection.
- REQ-021 SHALL, in FLUSH and DEAD, register io_en_a = 0, io_valid = 0, io_rule_idx = 0; io_deadlock = 1 in DEAD.
- REQ-022 SHALL give the idle-counter comparison priority in the same cycle: the cycle in which the counter reaches DEADLOCK_LIMIT enters DEAD and enables nothing.

Reset
- REQ-023 SHALL, while reset is high, set state = FLUSH, pointer = 0, idle counter = 0, io_en_a = 0, io_valid = 0, io_rule_idx = 0, io_deadlock = 0, io_fire_count = 0, and the LFSR = 0x01 when present.
- REQ-024 SHALL apply reset asserted mid-operation, including in DEAD, on the next rising edge, overriding all other updates.

Configuration
- REQ-025 SHALL, when macro RULE_SCHED_LFSR_EN is defined, include an 8-bit Galois LFSR (polynomial x^8+x^6+x^5+x^4+1) advanced on every non-stalled RUN cycle, with start index = LFSR[log2(NUM_RULES)-1:0]; the pointer is then not used.
- REQ-026 SHALL, when RULE_SCHED_LFSR_EN is undefined, use the round-robin pointer as start index and contain no LFSR logic.

Verification
- REQ-027 SHALL cover reset behaviour: reset high 1 cycle, io_guard = 4'b0010 -> cycle 1 (FLUSH) io_en_a = 0000; cycle 2 io_en_a = 0010, io_rule_idx = 1.
- REQ-028 SHALL cover round-robin, with the macro undefined: io_guard = 4'b1111 held 8 cycles -> io_en_a sequence 0001, 0010, 0100, 1000, 0001, ...; io_fire_count = 8.
- REQ-029 SHALL cover wrap-around: pointer = 3, io_guard = 4'b0011 -> io_en_a = 0001, next 0010.
- REQ-030 SHALL cover stall: io_stall high 3 cycles with io_guard = 1111 -> io_en_a = 0, io_fire_count unchanged; after release, the sequence resumes at the held pointer.
- REQ-031 SHALL cover deadlock: io_guard = 0 for 8 non-stalled RUN cycles -> io_deadlock = 1 sticky; a later io_guard = 1111 gives io_en_a = 0 until reset.
- REQ-032 SHALL cover the LFSR build: with RULE_SCHED_LFSR_EN and io_guard = 1111 for 100 cycles -> exactly one-hot io_en_a every cycle, each rule fired at least once.

Source files
------------

// File: rtl/rule_scheduler_if.sv
// Scheduler <-> downstream-system bundle: guards/stall in, registered enable and status out.
interface rule_scheduler_if #(
  parameter int NUM_RULES = 4,
  parameter int CNT_W     = 16
);
  localparam int IDX_W = $clog2(NUM_RULES);

  logic [NUM_RULES-1:0] io_guard;
  logic                 io_stall;
  logic [NUM_RULES-1:0] io_en_a;
  logic                 io_valid;
  logic [IDX_W-1:0]     io_rule_idx;
  logic                 io_deadlock;
  logic [CNT_W-1:0]     io_fire_count;

  modport master (
    output io_guard, io_stall,
    input  io_en_a, io_valid, io_rule_idx, io_deadlock, io_fire_count
  );

  modport slave (
    input  io_guard, io_stall,
    output io_en_a, io_valid, io_rule_idx, io_deadlock, io_fire_count
  );
endinterface

// File: rtl/rule_scheduler.sv
// Picks at most one true-guard rule per cycle (latency 1, stall freezes scheduling), with deadlock watchdog.
// Optional RULE_SCHED_LFSR_EN: pseudo-random start index from an 8-bit Galois LFSR instead of round-robin.
module rule_scheduler #(
  parameter int NUM_RULES      = 4,
  parameter int DEADLOCK_LIMIT = 8,
  parameter int CNT_W          = 16
) (
  input  logic            clock,
  input  logic            reset,
  rule_scheduler_if.slave bus
);
  localparam int                   IDX_W = $clog2(NUM_RULES);
  localparam logic [7:0]           LIMIT = 8'(DEADLOCK_LIMIT);
  localparam logic [NUM_RULES-1:0] ONE   = NUM_RULES'(1);

  typedef enum logic [1:0] {FLUSH, RUN, DEAD} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [7:0]           idle_q, idle_d;
  logic [NUM_RULES-1:0] en_q, en_d;
  logic                 valid_q, valid_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 dead_q, dead_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [IDX_W-1:0]     start_idx;
  logic [IDX_W-1:0]     cand;
  logic [IDX_W-1:0]     sel_idx;
  logic                 sel_found;

`ifdef RULE_SCHED_LFSR_EN
  logic [7:0] lfsr_q, lfsr_d;
  assign start_idx = lfsr_q[IDX_W-1:0];
`else
  assign start_idx = ptr_q;
`endif

  // First set guard at or after start_idx; index arithmetic wraps since NUM_RULES is a power of two.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_RULES; i++) begin
      cand = start_idx + IDX_W'(i);
      if (!sel_found && bus.io_guard[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idle_d  = idle_q;
    en_d    = '0;
    valid_d = 1'b0;
    idx_d   = '0;
    dead_d  = dead_q;
    cnt_d   = cnt_q;
`ifdef RULE_SCHED_LFSR_EN
    lfsr_d  = lfsr_q;
`endif
    case (state_q)
      FLUSH: state_d = RUN;
      RUN: begin
        if (!bus.io_stall) begin
`ifdef RULE_SCHED_LFSR_EN
          lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 8'hB8) : (lfsr_q >> 1);
`endif
          if (!sel_found) begin
            idle_d = idle_q + 8'd1;
            if (idle_d >= LIMIT) begin
              state_d = DEAD;
              dead_d  = 1'b1;
            end
          end else begin
            idle_d  = '0;
            en_d    = ONE << sel_idx;
            valid_d = 1'b1;
            idx_d   = sel_idx;
            ptr_d   = sel_idx + IDX_W'(1);
            if (cnt_q != {CNT_W{1'b1}})
              cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DEAD:    dead_d  = 1'b1;
      default: state_d = FLUSH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FLUSH;
      ptr_q   <= '0;
      idle_q  <= '0;
      en_q    <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      dead_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef RULE_SCHED_LFSR_EN
      lfsr_q  <= 8'h01;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idle_q  <= idle_d;
      en_q    <= en_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      dead_q  <= dead_d;
      cnt_q   <= cnt_d;
`ifdef RULE_SCHED_LFSR_EN
      lfsr_q  <= lfsr_d;
`endif
    end
  end

  assign bus.io_en_a       = en_q;
  assign bus.io_valid      = valid_q;
  assign bus.io_rule_idx   = idx_q;
  assign bus.io_deadlock   = dead_q;
  assign bus.io_fire_count = cnt_q;
endmodule

// File: tb/tb_rule_scheduler.sv
// Bench for rule_scheduler: directed vector table, randomized run against a reference model, counter saturation.
module tb_rule_scheduler;
  localparam int N     = 4;
  localparam int LIMIT = 8;

  logic clock;
  logic reset;

  rule_scheduler_if #(.NUM_RULES(N), .CNT_W(16)) bus ();
  rule_scheduler_if #(.NUM_RULES(N), .CNT_W(3))  bus_s ();

  rule_scheduler #(.NUM_RULES(N), .DEADLOCK_LIMIT(LIMIT), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave));
  rule_scheduler #(.NUM_RULES(N), .DEADLOCK_LIMIT(LIMIT), .CNT_W(3)) dut_s (
    .clock(clock), .reset(reset), .bus(bus_s.slave));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0=flush 1=run 2=dead; state kept as plain integers.
  int m_phase, m_ptr, m_idle, m_lfsr;
  int e_en, e_valid, e_idx, e_dead, e_cnt;

  task automatic model_step(input bit r, input bit s, input int g);
    int start, k;
    if (r) begin
      m_phase = 0; m_ptr = 0; m_idle = 0; m_lfsr = 1;
      e_en = 0; e_valid = 0; e_idx = 0; e_dead = 0; e_cnt = 0;
      return;
    end
    e_en = 0; e_valid = 0; e_idx = 0;
    if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 2) begin
      e_dead = 1;
    end else if (!s) begin
`ifdef RULE_SCHED_LFSR_EN
      start = m_lfsr % N;
      if (m_lfsr % 2 == 1) m_lfsr = (m_lfsr / 2) ^ 'hB8;
      else                 m_lfsr = m_lfsr / 2;
`else
      start = m_ptr;
`endif
      if (g == 0) begin
        m_idle++;
        if (m_idle >= LIMIT) begin
          m_phase = 2;
          e_dead  = 1;
        end
      end else begin
        m_idle = 0;
        k = -1;
        for (int o = 0; o < N && k < 0; o++)
          if ((g >> ((start + o) % N)) % 2 == 1) k = (start + o) % N;
        e_en = 1 << k; e_valid = 1; e_idx = k;
        m_ptr = (k + 1) % N;
        if (e_cnt < 65535) e_cnt++;
      end
    end
  endtask

  task automatic step(input bit r, input bit s, input logic [3:0] g);
    reset        = r;
    bus.io_stall = s;
    bus.io_guard = g;
    model_step(r, s, int'(g));
    @(posedge clock);
    #1;
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".en_a"},    int'(bus.io_en_a),       e_en);
    check({tag, ".valid"},   int'(bus.io_valid),      e_valid);
    check({tag, ".idx"},     int'(bus.io_rule_idx),   e_idx);
    check({tag, ".dead"},    int'(bus.io_deadlock),   e_dead);
    check({tag, ".count"},   int'(bus.io_fire_count), e_cnt);
    check({tag, ".onehot"},  int'($countones(bus.io_en_a) <= 1), 1);
  endtask

  typedef struct {
    bit          rst;
    bit          stall;
    logic [3:0]  guard;
    logic [3:0]  en;
    bit          valid;
    logic [1:0]  idx;
    bit          dead;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit r, input bit s, input logic [3:0] g, input logic [3:0] en,
                              input bit v, input logic [1:0] i, input bit d, input logic [15:0] c);
    vec_t t;
    t.rst = r; t.stall = s; t.guard = g; t.en = en; t.valid = v; t.idx = i; t.dead = d; t.cnt = c;
    vecs.push_back(t);
  endfunction

  int fired [N];

  initial begin
    reset = 1'b1;
    bus.io_guard   = '0;
    bus.io_stall   = 1'b0;
    bus_s.io_guard = 4'b1111;
    bus_s.io_stall = 1'b0;

`ifndef RULE_SCHED_LFSR_EN
    // Reset/latency, rotation from pointer, stall hold and resume, wrap-around from pointer 3.
    add(1, 0, 4'b0010, 4'b0000, 0, 0, 0, 0);
    add(0, 0, 4'b0010, 4'b0000, 0, 0, 0, 0);
    add(0, 0, 4'b0010, 4'b0010, 1, 1, 0, 1);
    add(0, 0, 4'b1111, 4'b0100, 1, 2, 0, 2);
    add(0, 0, 4'b1111, 4'b1000, 1, 3, 0, 3);
    add(0, 0, 4'b1111, 4'b0001, 1, 0, 0, 4);
    add(0, 0, 4'b1111, 4'b0010, 1, 1, 0, 5);
    for (int i = 0; i < 3; i++) add(0, 1, 4'b1111, 4'b0000, 0, 0, 0, 5);
    add(0, 0, 4'b1111, 4'b0100, 1, 2, 0, 6);
    add(0, 0, 4'b0011, 4'b0001, 1, 0, 0, 7);
    add(0, 0, 4'b0011, 4'b0010, 1, 1, 0, 8);
    // Eight cycles of all guards from a fresh reset.
    add(1, 0, 4'b1111, 4'b0000, 0, 0, 0, 0);
    add(0, 0, 4'b1111, 4'b0000, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      add(0, 0, 4'b1111, 4'(1 << (i % 4)), 1, 2'(i % 4), 0, 16'(i + 1));
    // Deadlock: a fire clears the idle count, stall does not advance it, 8th idle cycle trips.
    add(1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    add(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) add(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    add(0, 0, 4'b0001, 4'b0001, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 1);
    add(0, 1, 4'b0000, 4'b0000, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) add(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 1);
    add(0, 0, 4'b0000, 4'b0000, 0, 0, 1, 1);
    add(0, 0, 4'b1111, 4'b0000, 0, 0, 1, 1);
    add(0, 0, 4'b1111, 4'b0000, 0, 0, 1, 1);
    add(1, 0, 4'b1111, 4'b0000, 0, 0, 0, 0);
    add(0, 0, 4'b1111, 4'b0000, 0, 0, 0, 0);
    add(0, 0, 4'b1111, 4'b0001, 1, 0, 0, 1);

    foreach (vecs[n]) begin
      step(vecs[n].rst, vecs[n].stall, vecs[n].guard);
      check($sformatf("vec%0d.en_a", n),  int'(bus.io_en_a),       int'(vecs[n].en));
      check($sformatf("vec%0d.valid", n), int'(bus.io_valid),      int'(vecs[n].valid));
      check($sformatf("vec%0d.idx", n),   int'(bus.io_rule_idx),   int'(vecs[n].idx));
      check($sformatf("vec%0d.dead", n),  int'(bus.io_deadlock),   int'(vecs[n].dead));
      check($sformatf("vec%0d.count", n), int'(bus.io_fire_count), int'(vecs[n].cnt));
    end
`else
    // Pseudo-random start: every cycle exactly one rule fires, all rules get a turn.
    step(1, 0, 4'b1111);
    compare_model("lfsr_rst");
    step(0, 0, 4'b1111);
    compare_model("lfsr_flush");
    for (int c = 0; c < 100; c++) begin
      step(0, 0, 4'b1111);
      compare_model("lfsr");
      check("lfsr.exact_onehot", $countones(bus.io_en_a), 1);
      fired[bus.io_rule_idx]++;
    end
    for (int r = 0; r < N; r++) check($sformatf("lfsr.rule%0d_fired", r), int'(fired[r] > 0), 1);
`endif

    // Randomized run with zero-guard bursts so deadlock and its reset recovery get exercised.
    step(1, 0, 4'b0000);
    compare_model("rnd_rst");
    for (int c = 0; c < 600; c++) begin
      bit         r, s;
      logic [3:0] g;
      r = ($urandom_range(0, 99) < 2);
      s = ($urandom_range(0, 99) < 15);
      g = ((c / 40) % 3 == 1) ? 4'b0000 : 4'($urandom_range(0, 15));
      step(r, s, g);
      compare_model("rnd");
    end

    // Narrow counter sticks at all-ones.
    step(1, 0, 4'b1111);
    step(0, 0, 4'b1111);
    check("sat.after_flush", int'(bus_s.io_fire_count), 0);
    for (int i = 0; i < 7; i++) step(0, 0, 4'b1111);
    check("sat.reach_max", int'(bus_s.io_fire_count), 7);
    for (int i = 0; i < 3; i++) step(0, 0, 4'b1111);
    check("sat.hold_max", int'(bus_s.io_fire_count), 7);
    check("sat.still_firing", int'(bus_s.io_valid), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
